// File: rtl/uart_rx_core.sv
// UART receiver: start detect, 3-sample majority bit sampling, LSB-first deserializer,
// optional parity check and 1/2 stop bits with early resync at the final stop decision.
module uart_rx_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_error,
  output logic                  stop_error,
  output logic                  busy
);

  localparam int unsigned BitCntW = 4;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                    s0_q, s0_d, s1_q, s1_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic                    par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic                    par_flag_q, par_flag_d, stop_flag_q, stop_flag_d;
  logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
  logic                    data_valid_q, data_valid_d;
  logic                    par_error_q, par_error_d;
  logic                    stop_error_q, stop_error_d;

  logic [PRESCALE_W-1:0]   half;
  logic                    last_edge, decide, maj, stop_now;

  assign half      = presc_q >> 1;
  assign last_edge = (edge_cnt_q == presc_q - PRESCALE_W'(1));
  assign decide    = (edge_cnt_q == half + PRESCALE_W'(1));
  // Third sample is taken live in the decision cycle.
  assign maj       = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    shift_d      = shift_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    stop2_d      = stop2_q;
    par_flag_d   = par_flag_q;
    stop_flag_d  = stop_flag_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_error_d  = 1'b0;
    stop_error_d = 1'b0;
    stop_now     = 1'b0;

    if (state_q != StIdle) begin
      if (last_edge) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BitCntW'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
      if (edge_cnt_q == half - PRESCALE_W'(1)) s0_d = RX_IN;
      if (edge_cnt_q == half)                  s1_d = RX_IN;
    end

    unique case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          state_d     = StStart;
          presc_d     = Prescale;
          par_en_d    = PAR_EN;
          par_typ_d   = PAR_TYP;
          stop2_d     = STOP2;
          par_flag_d  = 1'b0;
          stop_flag_d = 1'b0;
        end
      end
      StStart: begin
        if (decide && maj) begin
          state_d = StIdle;
        end else if (last_edge) begin
          state_d = StData;
        end
      end
      StData: begin
        if (decide) begin
          for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt_q == BitCntW'(i)) shift_d[i] = maj;
          end
        end
        if (last_edge && (bit_cnt_q == BitCntW'(DATA_WIDTH - 1))) begin
          state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (decide) par_flag_d = (((^shift_q) ^ maj) != par_typ_q);
        if (last_edge) state_d = StStop;
      end
      StStop: begin
        if (decide) begin
          stop_now    = stop_flag_q | ~maj;
          stop_flag_d = stop_now;
          if (bit_cnt_q == BitCntW'(stop2_q)) begin
            state_d      = StIdle;
            par_error_d  = par_flag_q;
            stop_error_d = stop_now;
            if (!par_flag_q && !stop_now) begin
              p_data_d     = shift_q;
              data_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) bit_cnt_d = '0;
    if (state_d == StIdle) edge_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      shift_q      <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      stop2_q      <= 1'b0;
      par_flag_q   <= 1'b0;
      stop_flag_q  <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_error_q  <= 1'b0;
      stop_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      shift_q      <= shift_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      stop2_q      <= stop2_d;
      par_flag_q   <= par_flag_d;
      stop_flag_q  <= stop_flag_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_error_q  <= par_error_d;
      stop_error_q <= stop_error_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_error  = par_error_q;
  assign stop_error = stop_error_q;
  assign busy       = (state_q != StIdle);

endmodule
